// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
//
// Instruction prefetch unit placed directly in front of decode. It issues
// word-aligned fetch requests to a request/response instruction memory and
// buffers returned instructions, together with their PCs, in a DEPTH-entry
// in-order queue. Decode drains the queue through a valid/ready handshake.
// A redirect from execute flushes the queue, restarts fetch at the new PC
// and arranges for every response still in flight to be thrown away.
//
// Parameters:
//   DEPTH     queue entries and max outstanding requests (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous reset, active-high
//   imem_req     request valid towards instruction memory
//   imem_addr    request word address (bits [1:0] always zero)
//   imem_ready   memory accepts the request this cycle
//   imem_rvalid  response valid, in order, one per accepted request
//   imem_rdata   response instruction word
//   redirect     one-cycle pulse: flush and restart fetch
//   redirect_pc  new fetch address (bits [1:0] ignored)
//   inst_valid   queue head holds a valid instruction
//   inst         head instruction
//   inst_pc      PC of head instruction
//   inst_ready   decode consumes the head this cycle
// ----------------------------------------------------------------------------
module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [31:0]      fetch_pc;
   logic [31:0]      resp_pc;
   logic [31:0]      q_inst [DEPTH];
   logic [31:0]      q_pc   [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] drop;

   logic [CNT_W:0]   credit_used;
   logic             accept;
   logic             push;
   logic             pop;
   logic [31:0]      aligned_pc;
   logic             unused_pc_bits;

   assign unused_pc_bits = ^redirect_pc[1:0];
   assign aligned_pc     = {redirect_pc[31:2], 2'b00};

   // A request is only issued when a queue slot is reserved for its
   // response, counting both filled entries and responses still in flight,
   // so a returning response can never find the queue full.
   assign credit_used = {1'b0, count} + {1'b0, outstanding};
   assign imem_req    = !rst && !redirect && (credit_used < DEPTH_C);
   assign imem_addr   = fetch_pc;
   assign accept      = imem_req && imem_ready;

   // Responses that belong to a flushed fetch stream are absorbed by the
   // drop counter instead of being written into the queue.
   assign push        = imem_rvalid && (drop == '0);
   assign inst_valid  = (count != '0);
   assign pop         = inst_valid && inst_ready;
   assign inst        = q_inst[rd_ptr];
   assign inst_pc     = q_pc[rd_ptr];

   // Control state: fetch/response PCs, pointers and the three counters.
   // A redirect clears the queue and converts every in-flight response that
   // is not returning this very cycle into a pending drop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
      end else begin
         outstanding <= outstanding + CNT_W'(accept) - CNT_W'(imem_rvalid);
         if (redirect) begin
            fetch_pc <= aligned_pc;
            resp_pc  <= aligned_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop     <= outstanding - CNT_W'(imem_rvalid);
         end else begin
            if (accept) begin
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
               wr_ptr  <= wr_ptr + PTR_ONE;
               resp_pc <= resp_pc + 32'd4;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (imem_rvalid && (drop != '0)) begin
               drop <= drop - CNT_W'(1);
            end
         end
      end
   end

   // Queue storage needs no reset: entries are only observed once count
   // says they have been written since the last reset or flush.
   always_ff @(posedge clk) begin
      if (push) begin
         q_inst[wr_ptr] <= imem_rdata;
         q_pc[wr_ptr]   <= resp_pc;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// ----------------------------------------------------------------------------
// tb_ifetch_queue
//
// Self-checking bench for ifetch_queue. A behavioural model keeps the fetch
// queue as a queue of PCs plus plain counters, and a memory model returns
// responses in order with a programmable latency. Directed scenarios cover
// startup, backpressure, redirects, memory stalls and mid-run reset, then a
// randomized phase mixes everything.
// ----------------------------------------------------------------------------
module tb_ifetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference model state
   logic [31:0] modelFetch;
   logic [31:0] modelResp;
   logic [31:0] modelQueue[$];
   int          modelOut;
   int          modelDrop;
   logic [31:0] memAddr[$];
   int          memDue[$];
   int          cycleNum = 0;
   int          latMax   = 1;

   ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_ready  (inst_ready)
   );

   always #5 clk = ~clk;

   // Instruction memory contents as a fixed function of the word address.
   function automatic logic [31:0] memData(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                  tag, observed, expected, cycleNum);
      end
   endtask

   task automatic resetModel();
      modelFetch = RESET_PC;
      modelResp  = RESET_PC;
      modelQueue.delete();
      modelOut   = 0;
      modelDrop  = 0;
      memAddr.delete();
      memDue.delete();
   endtask

   // Applies reset from a falling edge, checks outputs while it is held and
   // releases it on the next falling edge.
   task automatic doReset();
      rst         = 1'b1;
      imem_ready  = 1'b0;
      inst_ready  = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      resetModel();
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_req",   {31'b0, imem_req},   32'd0);
      checkOutput("rst_valid", {31'b0, inst_valid}, 32'd0);
      checkOutput("rst_addr",  imem_addr,           RESET_PC);
      rst = 1'b0;
   endtask

   // One clock cycle, entered and left just after a falling edge: drive the
   // inputs, compare outputs with the model, then advance the model across
   // the rising edge.
   task automatic applyStimulus(input logic rdy, input logic irdy,
                                input logic redir, input logic [31:0] rpc,
                                input logic allowResp);
      logic rvNow;
      logic expReq;
      int   used;
      imem_ready  = rdy;
      inst_ready  = irdy;
      redirect    = redir;
      redirect_pc = rpc;
      rvNow       = allowResp && (memAddr.size() > 0) && (memDue[0] <= cycleNum);
      imem_rvalid = rvNow;
      imem_rdata  = rvNow ? memData(memAddr[0]) : $urandom;
      #1;
      used   = modelQueue.size() + modelOut;
      expReq = !redir && (used < DEPTH);
      checkOutput("imem_req",   {31'b0, imem_req},   {31'b0, expReq});
      checkOutput("imem_addr",  imem_addr,           modelFetch);
      checkOutput("inst_valid", {31'b0, inst_valid}, {31'b0, modelQueue.size() != 0});
      if (modelQueue.size() != 0) begin
         checkOutput("inst_pc", inst_pc, modelQueue[0]);
         checkOutput("inst",    inst,    memData(modelQueue[0]));
      end
      checkOutput("invariant",
                  {31'b0, (int'(dut.count) <= DEPTH) &&
                          (int'(dut.count) + int'(dut.outstanding) <= DEPTH) &&
                          (int'(dut.drop) <= int'(dut.outstanding))},
                  32'd1);
      @(posedge clk);
      cycleNum++;
      if (expReq && rdy) begin
         memAddr.push_back(modelFetch);
         memDue.push_back(cycleNum + $urandom_range(latMax - 1, 0));
         modelOut++;
         modelFetch = modelFetch + 32'd4;
      end
      if ((modelQueue.size() != 0) && irdy) begin
         void'(modelQueue.pop_front());
      end
      if (rvNow) begin
         void'(memAddr.pop_front());
         void'(memDue.pop_front());
         modelOut--;
         if (modelDrop > 0) begin
            modelDrop--;
         end else begin
            modelQueue.push_back(modelResp);
            modelResp = modelResp + 32'd4;
         end
      end
      if (redir) begin
         modelQueue.delete();
         modelDrop  = modelOut;
         modelFetch = {rpc[31:2], 2'b00};
         modelResp  = modelFetch;
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      imem_ready  = 1'b0;
      inst_ready  = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      @(negedge clk);

      // Startup with a single-cycle memory and a always-ready decode
      latMax = 1;
      doReset();
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);

      // Decode backpressure fills the queue, then a single pop frees a credit
      doReset();
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
      checkOutput("bp_count", 32'(dut.count), 32'd4);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);

      // Redirect with one queued entry and two responses in flight
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
      checkOutput("redir_drop", 32'(dut.drop), 32'd2);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);

      // Misaligned redirect while a response returns in the same cycle
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h43, 1'b1);
      checkOutput("mis_drop", 32'(dut.drop), 32'd1);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);

      // Memory stall: request held with a stable address
      doReset();
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
      checkOutput("stall_out", 32'(dut.outstanding), 32'd0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);

      // Reset mid-operation with three entries queued and one outstanding
      doReset();
      for (int i = 0; i < 20; i++) begin
         if ((modelQueue.size() == 3) && (modelOut == 1)) break;
         applyStimulus(1'b1, 1'b0, 1'b0, '0, modelQueue.size() < 3);
      end
      checkOutput("pre_rst_valid", {31'b0, inst_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_valid", {31'b0, inst_valid}, 32'd0);
      checkOutput("async_req",   {31'b0, imem_req},   32'd0);
      checkOutput("async_addr",  imem_addr,           RESET_PC);
      resetModel();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);

      // Address wrap past the top of the address space
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF9, 1'b1);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b1);

      // Randomized traffic with variable latency, stalls and redirects
      latMax = 3;
      for (int i = 0; i < 1500; i++) begin
         applyStimulus($urandom_range(99) < 75,
                       $urandom_range(99) < 60,
                       $urandom_range(99) < 5,
                       $urandom & 32'h0000_0FFF,
                       $urandom_range(99) < 80);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Instruction prefetch unit sitting directly upstream of decode. It replaces the combinational PC/instruction-ROM path with a request/response instruction-memory interface and a DEPTH-entry in-order queue of (instruction, PC) pairs. Decode consumes entries through a valid/ready handshake. A taken branch or jump from execute redirects fetch, which flushes the queue and discards in-flight responses.

Parameters:
DEPTH, 4, queue entries and max outstanding requests (power of two, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-high
imem_req  out  1  request valid to instruction memory
imem_addr  out  32  request word address, bits[1:0] always 0
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid, in order, one per accepted request
imem_rdata  in  32  response instruction word
redirect  in  1  one-cycle pulse: flush and restart fetch
redirect_pc  in  32  new fetch address; bits[1:0] ignored
inst_valid  out  1  queue head holds a valid instruction
inst  out  32  head instruction
inst_pc  out  32  PC of head instruction
inst_ready  in  1  decode consumes head this cycle

Behaviour:
- State: fetch_pc (next request address), resp_pc (PC of next accepted response), queue storage plus rd/wr pointers, count (0..DEPTH), outstanding (0..DEPTH), drop (0..DEPTH).
- Reset (async, any time): fetch_pc = resp_pc = RESET_PC, pointers, count, outstanding and drop = 0. Outputs during and after reset: imem_req = 0, inst_valid = 0, imem_addr = RESET_PC, inst and inst_pc don't-care.
- imem_addr = fetch_pc. imem_req = !rst && !redirect && (count + outstanding < DEPTH). This credit rule guarantees every response has a queue slot, so responses never overflow.
- Accept: imem_req && imem_ready. On accept, outstanding += 1 and fetch_pc += 4, wrapping modulo 2^32. While imem_req is high and imem_ready is low, imem_addr holds stable.
- Response: on imem_rvalid, outstanding -= 1.
  - If drop > 0: drop -= 1 and the data is discarded.
  - Otherwise: push {imem_rdata, resp_pc}, resp_pc += 4, count += 1.
- Pop: inst_valid && inst_ready advances rd_ptr, count -= 1. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- inst_valid = (count != 0). inst/inst_pc are read combinationally from the head entry, so a response written at edge N is visible to decode in cycle N+1.
- Redirect, evaluated at the edge where redirect = 1:
  - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}; pointers and count cleared.
  - drop = outstanding - imem_rvalid, i.e. all in-flight responses not returning this cycle. A response arriving in the redirect cycle is itself discarded.
  - Any pop in that cycle counts as consumed; the rest of the queue is lost.
  - No request is issued in the redirect cycle. Fetch at the new PC starts in the next cycle.
  - Back-to-back redirects: the last one wins, and drop is recomputed each time.
- Memory contract (not checked by this block): imem_rvalid never exceeds accepted requests, and responses are in order with latency >= 1 cycle.
- Bench assertions: count <= DEPTH; count + outstanding <= DEPTH; drop <= outstanding.

Test Plan:
1. Startup: reset, then release with 1-cycle memory, imem_ready = 1, inst_ready = 1.
   -> Requests go out at 0x0, 0x4, 0x8, …
   -> inst_pc sequence is 0x0, 0x4, 0x8 with matching inst, one per cycle in steady state.
2. Backpressure: inst_ready = 0, memory always ready.
   -> Exactly 4 requests issue (0x0–0xC), then imem_req = 0, count = 4.
   -> After inst_ready rises, one pop frees one credit, so the next request is 0x10.
3. Redirect with drops: 2 requests outstanding, queue holding 0x0, then redirect with redirect_pc = 0x40.
   -> The 2 late responses are dropped and inst_valid = 0 until the response for 0x40 arrives.
   -> The first popped inst_pc after the redirect is 0x40.
4. Misaligned redirect plus same-cycle response: redirect_pc = 0x43 while imem_rvalid = 1.
   -> That response is discarded and drop = outstanding - 1.
   -> Next imem_addr = 0x40.
5. Memory stall: imem_ready = 0 for 5 cycles while imem_req = 1.
   -> imem_addr is held at the same value for all 5 cycles, outstanding is unchanged, no duplicate address is issued.
6. Reset mid-operation: assert rst asynchronously between clock edges with 3 entries queued and 1 outstanding.
   -> inst_valid and imem_req fall immediately.
   -> After release, the first request is RESET_PC and a stale response arriving after release is not pushed (the bench must not drive it).
